iprf_wr_arb: RTL and testbench
==============================

# iprf_wr_arb

Shares the single integer PRF write port among `NUM_SRC` result producers, for example the EINT execution pipe and the load pipe. Each source pushes PRF write packets into a private `FIFO_DEPTH`-entry skid FIFO using a valid/ready handshake. A round-robin arbiter picks one FIFO head per cycle and drives it onto the PRF write port, which can backpressure. The block sits between the execution units' `*_ex1` result stage and the rename/PRF write logic, and also counts contention cycles for performance debug.

## Interface
- `NUM_SRC`, default 2: number of result sources (2..4).
- `PKT_W`, default 64: width of one PRF write packet. Packet contents are opaque to this block.
- `FIFO_DEPTH`, default 2: entries per source FIFO (power of two, ≥2).
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `src_valid` input `NUM_SRC`: source i presents a packet.
- `src_pkt` input `NUM_SRC` × `PKT_W`: packet for each source.
- `src_ready` output `NUM_SRC`: source i's FIFO can accept a packet this cycle.
- `wr_valid` output 1: a PRF write is presented.
- `wr_pkt` output `PKT_W`: the presented packet.
- `wr_src` output `$clog2(NUM_SRC)` (min 1): index of the source that owns `wr_pkt`.
- `wr_ready` input 1: the PRF write port accepts the packet this cycle.
- `conflict_cnt` output 32: count of cycles with ≥2 non-empty FIFOs. Saturates at `0xFFFF_FFFF`.

## Operation
- Push to FIFO i happens when `src_valid[i] & src_ready[i]`.
  - `src_ready[i] = !reset & (count_i < FIFO_DEPTH)`.
  - `src_ready` is derived only from registered state. There is no combinational path from `wr_ready` or `src_valid`.
  - A full FIFO does not accept a push, even in a cycle where it pops.
- Pop from FIFO i happens when `wr_valid & wr_ready & (wr_src == i)`.
- Push and pop of the same FIFO in the same cycle are legal; `count_i` is unchanged.
- Each FIFO has a read pointer and a write pointer that wrap modulo `FIFO_DEPTH`, plus a count of width `$clog2(FIFO_DEPTH)+1`.
- Arbiter state:
  - `locked`: 1 bit.
  - `grant`: source index.
  - `rr_ptr`: index of the highest-priority source.
- When `locked == 0`: choose the first non-empty FIFO scanning `rr_ptr`, `rr_ptr+1`, … modulo `NUM_SRC`. `wr_valid = 1` if any FIFO is non-empty.
- When `locked == 1`: present FIFO[`grant`]'s head unchanged.
- Lock rule:
  - If `wr_valid & !wr_ready`, set `locked = 1` and register the chosen source.
  - `wr_pkt` and `wr_src` then stay stable until they are accepted. A stall never changes the winner.
- Accept rule: on `wr_valid & wr_ready`, set `locked = 0` and `rr_ptr = wr_src + 1` (mod `NUM_SRC`).
- `conflict_cnt` increments in every cycle where at least two FIFOs have `count > 0`, sampled on the registered counts.
- Reset clears:
  - all FIFO counts and pointers,
  - `locked`, `grant`, `rr_ptr` to 0,
  - `conflict_cnt` to 0.
- Pushes presented during reset are dropped. FIFO contents need not be cleared.
- Reset mid-stall abandons all queued packets and the locked grant.

## Timing
- Latency: a packet pushed in cycle N can appear on `wr_valid`/`wr_pkt` in cycle N+1 at the earliest. There is no same-cycle bypass.
- `wr_valid`, `wr_pkt` and `wr_src` are combinational from registered FIFO/arbiter state.
- Reset values of outputs:
  - `src_ready = 0` while `reset` is high, all 1 in the first cycle after reset.
  - `wr_valid = 0`.
  - `wr_src = 0`.
  - `wr_pkt` don't-care (the bench must not check it).
  - `conflict_cnt = 0`.
- Sustained throughput: 1 packet/cycle total when `wr_ready` is held at 1. Each source gets ≥1 grant per `NUM_SRC` accepted writes while it is non-empty.
- Full FIFO:
  - `src_ready` drops in the cycle after the push that fills it.
  - It returns in the cycle after a pop.

## Test plan
- Reset, then single push on src0 of pkt `0xA5` in cycle 1, `wr_ready = 1` -> `wr_valid = 1`, `wr_pkt = 0xA5`, `wr_src = 0` in cycle 2; `wr_valid = 0` in cycle 3.
- Both sources push every cycle for 8 cycles, `wr_ready = 1` -> `wr_src` alternates 0,1,0,1…; no packet is lost or reordered within a source; `conflict_cnt` is ≥6 at the end.
- Fill src1 with `FIFO_DEPTH = 2` packets while `wr_ready = 0` -> `src_ready[1] = 0` from the cycle after the second push; a third `src_valid` is not accepted; packet order on drain is preserved.
- Stall: `wr_ready = 0` for 5 cycles while src0 is presented, then src1 becomes non-empty with `rr_ptr` favoring src1 -> `wr_pkt`/`wr_src` stay at src0's head for all 5 cycles; src0 is accepted first, then src1.
- Assert `reset` for 1 cycle with both FIFOs holding 2 entries and `locked = 1` -> cycle after reset: `wr_valid = 0`, `src_ready = 2'b11`, `conflict_cnt = 0`; the next push is the first packet output.
- Force `conflict_cnt` to `0xFFFF_FFFE` (hierarchical deposit), then hold 3 conflict cycles -> the counter reads `0xFFFF_FFFF` and does not wrap.

Source files
------------

// File: rtl/iprf_wr_arb.sv
// -----------------------------------------------------------------------------
// iprf_wr_arb
//
// Shares the single integer PRF write port among NUM_SRC result producers.
// Each source pushes opaque write packets into its own FIFO_DEPTH-entry skid
// FIFO. A round-robin arbiter presents one FIFO head per cycle on the PRF
// write port. Once a packet is presented and stalled, the arbiter locks onto
// it, so the presented packet does not change until it is accepted. A
// saturating counter records cycles in which two or more FIFOs hold data.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   src_valid     per-source packet valid
//   src_pkt       per-source packet
//   src_ready     per-source FIFO has room (registered state only)
//   wr_valid      PRF write presented
//   wr_pkt        presented packet
//   wr_src        index of the source that owns wr_pkt
//   wr_ready      PRF write port accepts the packet this cycle
//   conflict_cnt  saturating count of cycles with >=2 non-empty FIFOs
// -----------------------------------------------------------------------------
module iprf_wr_arb #(
  parameter int NUM_SRC    = 2,
  parameter int PKT_W      = 64,
  parameter int FIFO_DEPTH = 2,
  localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC-1:0][PKT_W-1:0]   src_pkt,
  output logic [NUM_SRC-1:0]              src_ready,
  output logic                            wr_valid,
  output logic [PKT_W-1:0]                wr_pkt,
  output logic [SRC_W-1:0]                wr_src,
  input  logic                            wr_ready,
  output logic [31:0]                     conflict_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // FIFO storage and bookkeeping
  logic [PKT_W-1:0]                mem_q [NUM_SRC][FIFO_DEPTH];
  logic [NUM_SRC-1:0][PTR_W-1:0]   rd_ptr_q;
  logic [NUM_SRC-1:0][PTR_W-1:0]   wr_ptr_q;
  logic [NUM_SRC-1:0][CNT_W-1:0]   count_q, count_d;
  logic [NUM_SRC-1:0]              nonempty;
  logic [NUM_SRC-1:0]              push;
  logic [NUM_SRC-1:0]              pop;

  // Arbiter state
  logic                            locked_q, locked_d;
  logic [SRC_W-1:0]                grant_q, grant_d;
  logic [SRC_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]                pick_idx;
  logic [SRC_W-1:0]                scan_idx;
  logic                            pick_found;
  logic [SRC_W-1:0]                sel;
  int                              scan;

  // Contention counter
  logic [31:0]                     conflict_cnt_q, conflict_cnt_d;
  logic                            conflict;

  // ---------------------------------------------------------------------------
  // Per-FIFO status. src_ready looks only at the registered count, so it has
  // no combinational dependence on wr_ready or src_valid; a full FIFO refuses
  // a push even in a cycle where it is being popped.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    src_ready = '0;
    nonempty  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = !reset && (count_q[i] < DEPTH_C);
      nonempty[i]  = (count_q[i] != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first non-empty FIFO starting at rr_ptr, modulo NUM_SRC.
  // ---------------------------------------------------------------------------
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    scan       = 0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= NUM_SRC) scan = scan - NUM_SRC;
      scan_idx = SRC_W'(scan);
      if (!pick_found && nonempty[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // A locked grant always points at a non-empty FIFO: that FIFO cannot be
  // popped until the locked packet is accepted, which also clears the lock.
  assign sel      = locked_q ? grant_q : pick_idx;
  assign wr_valid = locked_q | (|nonempty);
  assign wr_src   = sel;
  assign wr_pkt   = mem_q[sel][rd_ptr_q[sel]];

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      push[i] = src_valid[i] & src_ready[i];
      pop[i]  = wr_valid & wr_ready & (sel == SRC_W'(i));
    end
  end

  always_comb begin
    count_d = count_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + 1'b1;
        2'b01:   count_d[i] = count_q[i] - 1'b1;
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Lock / accept. A stall freezes the current winner; an accept releases the
  // lock and hands top priority to the source after the winner.
  // ---------------------------------------------------------------------------
  always_comb begin
    locked_d = locked_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (wr_valid) begin
      if (wr_ready) begin
        locked_d = 1'b0;
        if (int'(sel) == NUM_SRC - 1) rr_ptr_d = '0;
        else                          rr_ptr_d = sel + 1'b1;
      end else begin
        locked_d = 1'b1;
        grant_d  = sel;
      end
    end
  end

  // Contention is judged on the registered counts, not on this cycle's pushes.
  always_comb begin
    conflict       = ($countones(nonempty) >= 2);
    conflict_cnt_d = conflict_cnt_q;
    if (conflict && (conflict_cnt_q != '1)) conflict_cnt_d = conflict_cnt_q + 32'd1;
  end

  assign conflict_cnt = conflict_cnt_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      locked_q       <= 1'b0;
      grant_q        <= '0;
      rr_ptr_q       <= '0;
      conflict_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
      end
      count_q        <= count_d;
      locked_q       <= locked_d;
      grant_q        <= grant_d;
      rr_ptr_q       <= rr_ptr_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // NOTE: packet storage is deliberately not reset; the counts and pointers
  // alone decide what is valid, and leaving the array unreset keeps it a
  // plain register file / RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= src_pkt[i];
    end
  end

endmodule

// File: tb/tb_iprf_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_iprf_wr_arb
//
// Self-checking bench for iprf_wr_arb. Every accepted push is appended to a
// per-source expected queue; every accepted PRF write pops that source's queue
// and compares the packet. src_ready and wr_valid are compared each cycle
// against the queue occupancy. Directed sequences cover reset values, latency,
// round-robin alternation, full FIFO, stall stability, reset mid-stall and
// counter saturation.
// -----------------------------------------------------------------------------
module tb_iprf_wr_arb;

  localparam int NUM_SRC    = 2;
  localparam int PKT_W      = 64;
  localparam int FIFO_DEPTH = 2;
  localparam int SRC_W      = $clog2(NUM_SRC);

  logic                          clk = 1'b0;
  logic                          reset;
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0][PKT_W-1:0] src_pkt;
  logic [NUM_SRC-1:0]            src_ready;
  logic                          wr_valid;
  logic [PKT_W-1:0]              wr_pkt;
  logic [SRC_W-1:0]              wr_src;
  logic                          wr_ready;
  logic [31:0]                   conflict_cnt;

  int checks   = 0;
  int failures = 0;

  logic [PKT_W-1:0]   exp_q [NUM_SRC][$];
  logic               alt_mode = 1'b0;
  logic               alt_exp  = 1'b0;
  logic [NUM_SRC-1:0] last_push;
  int                 n_writes = 0;
  int                 seq [NUM_SRC];

  iprf_wr_arb #(
    .NUM_SRC    (NUM_SRC),
    .PKT_W      (PKT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_pkt      (src_pkt),
    .src_ready    (src_ready),
    .wr_valid     (wr_valid),
    .wr_pkt       (wr_pkt),
    .wr_src       (wr_src),
    .wr_ready     (wr_ready),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle. Handshakes are taken from the values that are stable
  // before the edge; outputs are compared 1 time unit after the edge.
  task automatic tick();
    logic [NUM_SRC-1:0] exp_rdy;
    logic               any;
    last_push = '0;
    if (!reset) begin
      if (wr_valid && wr_ready) begin
        n_writes++;
        if (alt_mode) begin
          check("alt_src", 64'(wr_src), 64'(alt_exp));
          alt_exp = ~alt_exp;
        end
        if (exp_q[wr_src].size() == 0) check("pop_nonempty", 64'd0, 64'd1);
        else                            check("wr_pkt", wr_pkt, exp_q[wr_src].pop_front());
      end
      last_push = src_valid & src_ready;
      for (int i = 0; i < NUM_SRC; i++)
        if (last_push[i]) exp_q[i].push_back(src_pkt[i]);
    end
    @(posedge clk);
    #1;
    if (reset)
      for (int i = 0; i < NUM_SRC; i++) exp_q[i].delete();
    any     = 1'b0;
    exp_rdy = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      exp_rdy[i] = !reset && (exp_q[i].size() < FIFO_DEPTH);
      any        = any | (exp_q[i].size() != 0);
    end
    check("src_ready", 64'(src_ready), 64'(exp_rdy));
    check("wr_valid", 64'(wr_valid), 64'(any));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    src_valid = '0;
    wr_ready  = 1'b0;
    tick();
    check("rst_wr_src", 64'(wr_src), 64'd0);
    check("rst_conflict", 64'(conflict_cnt), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(src_ready), 64'(2'b11));
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n         = 0;
    src_valid = '0;
    wr_ready  = 1'b1;
    while (wr_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check("drain_done", 64'(wr_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    src_valid = '0;
    src_pkt   = '0;
    wr_ready  = 1'b0;
    tick();
    do_reset();

    // ---- Single push, latency of one cycle --------------------------------
    src_valid  = 2'b01;
    src_pkt[0] = 64'hA5;
    wr_ready   = 1'b1;
    tick();
    check("t1_valid", 64'(wr_valid), 64'd1);
    check("t1_pkt", wr_pkt, 64'hA5);
    check("t1_src", 64'(wr_src), 64'd0);
    src_valid = '0;
    tick();
    check("t1_idle", 64'(wr_valid), 64'd0);

    // ---- Both sources streaming: strict alternation ------------------------
    do_reset();
    alt_mode = 1'b1;
    alt_exp  = 1'b0;
    n_writes = 0;
    seq[0]   = 0;
    seq[1]   = 0;
    wr_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        src_valid[i] = 1'b1;
        src_pkt[i]   = {32'(i + 16'h2000), 32'(seq[i])};
      end
      tick();
      for (int i = 0; i < NUM_SRC; i++)
        if (last_push[i]) seq[i]++;
    end
    drain(20);
    alt_mode = 1'b0;
    check("t2_writes", 64'(n_writes), 64'd10);
    check("t2_conflict_ge6", 64'(conflict_cnt >= 32'd6), 64'd1);

    // ---- Fill src1 while stalled ------------------------------------------
    do_reset();
    wr_ready   = 1'b0;
    src_valid  = 2'b10;
    src_pkt[1] = 64'h3100;
    tick();
    check("t3_ready_after1", 64'(src_ready[1]), 64'd1);
    src_pkt[1] = 64'h3101;
    tick();
    check("t3_full", 64'(src_ready[1]), 64'd0);
    src_pkt[1] = 64'h3102;
    tick();
    tick();
    check("t3_still_full", 64'(src_ready[1]), 64'd0);
    check("t3_head", wr_pkt, 64'h3100);
    src_valid = '0;
    wr_ready  = 1'b1;
    tick();
    check("t3_ready_back", 64'(src_ready[1]), 64'd1);
    check("t3_second", wr_pkt, 64'h3101);
    drain(10);

    // ---- Stall holds src0 although priority points at src1 ----------------
    do_reset();
    wr_ready   = 1'b1;
    src_valid  = 2'b01;
    src_pkt[0] = 64'h4000;
    tick();
    src_valid = '0;
    tick();                                 // src0 accepted, priority -> src1
    wr_ready   = 1'b0;
    src_valid  = 2'b01;
    src_pkt[0] = 64'h4001;
    tick();
    src_valid  = 2'b10;
    src_pkt[1] = 64'h4101;
    for (int c = 0; c < 5; c++) begin
      check("t4_stall_src", 64'(wr_src), 64'd0);
      check("t4_stall_pkt", wr_pkt, 64'h4001);
      tick();
      src_valid = '0;
    end
    wr_ready = 1'b1;
    check("t4_first_src", 64'(wr_src), 64'd0);
    tick();
    check("t4_second_src", 64'(wr_src), 64'd1);
    check("t4_second_pkt", wr_pkt, 64'h4101);
    drain(10);

    // ---- Reset while both FIFOs are full and the arbiter is locked -------
    do_reset();
    wr_ready  = 1'b0;
    src_valid = 2'b11;
    src_pkt   = {64'h5100, 64'h5000};
    tick();
    src_pkt   = {64'h5101, 64'h5001};
    tick();
    src_valid = '0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    #1;
    check("t5_valid", 64'(wr_valid), 64'd0);
    check("t5_ready", 64'(src_ready), 64'(2'b11));
    check("t5_conflict", 64'(conflict_cnt), 64'd0);
    src_valid  = 2'b10;
    src_pkt[1] = 64'h5199;
    wr_ready   = 1'b1;
    tick();
    check("t5_first_src", 64'(wr_src), 64'd1);
    check("t5_first_pkt", wr_pkt, 64'h5199);
    drain(10);

    // ---- Counter saturation ------------------------------------------------
    do_reset();
    wr_ready  = 1'b0;
    src_valid = 2'b11;
    src_pkt   = {64'h6100, 64'h6000};
    tick();
    src_valid = '0;
    dut.conflict_cnt_q <= 32'hFFFF_FFFE;
    #1;
    tick();
    check("t6_sat1", 64'(conflict_cnt), 64'hFFFF_FFFF);
    tick();
    tick();
    check("t6_sat3", 64'(conflict_cnt), 64'hFFFF_FFFF);
    drain(10);

    check("sb_empty", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
